// File: rtl/rc4_keystream_decryptor.sv
// RC4 keystream generator and decrypt stage.
// Walks the shuffled S RAM, XORs each keystream byte into the message.
module rc4_keystream_decryptor #(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_LENGTH     = 8,
  parameter int MSG_LENGTH     = 32,
  parameter int MSG_ADDR_WIDTH = 5,
  parameter int CHECK_CHARS    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      finished,
  output logic                      msg_valid,
  input  logic [RAM_WIDTH-1:0]      s_ram_out,
  output logic [RAM_LENGTH-1:0]     s_address,
  output logic [RAM_WIDTH-1:0]      s_ram_in,
  output logic                      s_write_enable,
  input  logic [RAM_WIDTH-1:0]      enc_rom_out,
  output logic [MSG_ADDR_WIDTH-1:0] enc_address,
  output logic [MSG_ADDR_WIDTH-1:0] dec_address,
  output logic [RAM_WIDTH-1:0]      dec_ram_in,
  output logic                      dec_write_enable
);

  localparam logic [MSG_ADDR_WIDTH-1:0] K_MAX =
    MSG_ADDR_WIDTH'(MSG_LENGTH - 1);
  localparam logic [MSG_ADDR_WIDTH-1:0] K_ONE =
    MSG_ADDR_WIDTH'(1);
  localparam logic [RAM_LENGTH-1:0] I_ONE =
    RAM_LENGTH'(1);

  // Each state names what is presented on the outputs
  // during that cycle; registers are loaded on entry.
  typedef enum logic [3:0] {
    IDLE,
    SET_I,
    WAIT_I,
    GET_SI,
    WAIT_J,
    GET_SJ,
    WR_J,
    SET_F,
    WAIT_F,
    GET_F,
    NEXT,
    DONE
  } state_t;

  state_t state, state_n;

  logic                      start_q;
  logic                      start_edge;
  logic [RAM_LENGTH-1:0]     i, i_n;
  logic [RAM_LENGTH-1:0]     j, j_n;
  logic [MSG_ADDR_WIDTH-1:0] k, k_n;
  logic [RAM_WIDTH-1:0]      si, si_n;
  logic [RAM_WIDTH-1:0]      sj, sj_n;

  logic                      finished_n;
  logic                      msg_valid_n;
  logic [RAM_LENGTH-1:0]     s_address_n;
  logic [RAM_WIDTH-1:0]      s_ram_in_n;
  logic                      s_write_enable_n;
  logic [MSG_ADDR_WIDTH-1:0] enc_address_n;
  logic [MSG_ADDR_WIDTH-1:0] dec_address_n;
  logic [RAM_WIDTH-1:0]      dec_ram_in_n;
  logic                      dec_write_enable_n;

  logic                      char_ok;
  logic                      abort;

  assign start_edge = start & ~start_q;

  // Accepted characters: space and lowercase letters.
  assign char_ok =
    (dec_ram_in == RAM_WIDTH'(8'h20)) ||
    ((dec_ram_in >= RAM_WIDTH'(8'h61)) &&
     (dec_ram_in <= RAM_WIDTH'(8'h7a)));

  assign abort = (CHECK_CHARS != 0) && !char_ok;

  // State, datapath and registered-output storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      start_q          <= 1'b0;
      i                <= '0;
      j                <= '0;
      k                <= '0;
      si               <= '0;
      sj               <= '0;
      finished         <= 1'b0;
      msg_valid        <= 1'b0;
      s_address        <= '0;
      s_ram_in         <= '0;
      s_write_enable   <= 1'b0;
      enc_address      <= '0;
      dec_address      <= '0;
      dec_ram_in       <= '0;
      dec_write_enable <= 1'b0;
    end else begin
      state            <= state_n;
      start_q          <= start;
      i                <= i_n;
      j                <= j_n;
      k                <= k_n;
      si               <= si_n;
      sj               <= sj_n;
      finished         <= finished_n;
      msg_valid        <= msg_valid_n;
      s_address        <= s_address_n;
      s_ram_in         <= s_ram_in_n;
      s_write_enable   <= s_write_enable_n;
      enc_address      <= enc_address_n;
      dec_address      <= dec_address_n;
      dec_ram_in       <= dec_ram_in_n;
      dec_write_enable <= dec_write_enable_n;
    end
  end

  // Next state and the values loaded on entering it.
  always_comb begin
    state_n            = state;
    i_n                = i;
    j_n                = j;
    k_n                = k;
    si_n               = si;
    sj_n               = sj;
    finished_n         = finished;
    msg_valid_n        = msg_valid;
    s_address_n        = s_address;
    s_ram_in_n         = s_ram_in;
    s_write_enable_n   = 1'b0;
    enc_address_n      = enc_address;
    dec_address_n      = dec_address;
    dec_ram_in_n       = dec_ram_in;
    dec_write_enable_n = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          state_n     = SET_I;
          i_n         = I_ONE;
          j_n         = '0;
          k_n         = '0;
          s_address_n = I_ONE;
          finished_n  = 1'b0;
          msg_valid_n = 1'b0;
        end
      end
      SET_I: begin
        state_n = WAIT_I;
      end
      WAIT_I: begin
        state_n     = GET_SI;
        si_n        = s_ram_out;
        j_n         = j + RAM_LENGTH'(s_ram_out);
        s_address_n = j + RAM_LENGTH'(s_ram_out);
      end
      GET_SI: begin
        state_n = WAIT_J;
      end
      WAIT_J: begin
        state_n          = GET_SJ;
        sj_n             = s_ram_out;
        s_address_n      = i;
        s_ram_in_n       = s_ram_out;
        s_write_enable_n = 1'b1;
      end
      GET_SJ: begin
        state_n          = WR_J;
        s_address_n      = j;
        s_ram_in_n       = si;
        s_write_enable_n = 1'b1;
      end
      WR_J: begin
        state_n       = SET_F;
        s_address_n   = RAM_LENGTH'(si + sj);
        enc_address_n = k;
      end
      SET_F: begin
        state_n = WAIT_F;
      end
      WAIT_F: begin
        state_n            = GET_F;
        dec_address_n      = k;
        dec_ram_in_n       = s_ram_out ^ enc_rom_out;
        dec_write_enable_n = 1'b1;
      end
      GET_F: begin
        if (abort) begin
          state_n     = DONE;
          finished_n  = 1'b1;
          msg_valid_n = 1'b0;
        end else begin
          state_n = NEXT;
        end
      end
      NEXT: begin
        if (k == K_MAX) begin
          state_n     = DONE;
          finished_n  = 1'b1;
          msg_valid_n = 1'b1;
        end else begin
          state_n     = SET_I;
          k_n         = k + K_ONE;
          i_n         = i + I_ONE;
          s_address_n = i + I_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_keystream_decryptor.sv
// Bench for rc4_keystream_decryptor: RAM/ROM models around the DUT,
// a plain RC4 reference and a per-cycle comparison of every strobe.
module tb_rc4_keystream_decryptor;

  localparam int ML = 32;
  localparam int NC = 10 * ML + 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       finished;
  logic       msg_valid;
  logic [7:0] s_ram_out;
  logic [7:0] s_address;
  logic [7:0] s_ram_in;
  logic       s_write_enable;
  logic [7:0] enc_rom_out;
  logic [4:0] enc_address;
  logic [4:0] dec_address;
  logic [7:0] dec_ram_in;
  logic       dec_write_enable;

  always #5 clk = ~clk;

  rc4_keystream_decryptor #(
    .RAM_WIDTH(8),
    .RAM_LENGTH(8),
    .MSG_LENGTH(ML),
    .MSG_ADDR_WIDTH(5),
    .CHECK_CHARS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .finished(finished),
    .msg_valid(msg_valid),
    .s_ram_out(s_ram_out),
    .s_address(s_address),
    .s_ram_in(s_ram_in),
    .s_write_enable(s_write_enable),
    .enc_rom_out(enc_rom_out),
    .enc_address(enc_address),
    .dec_address(dec_address),
    .dec_ram_in(dec_ram_in),
    .dec_write_enable(dec_write_enable)
  );

  logic [7:0] smem [256];
  logic [7:0] sinit[256];
  logic [7:0] emem [ML];
  logic [7:0] dmem [ML];
  logic       do_load = 1'b0;

  // Synchronous memories around the DUT.
  always @(posedge clk) begin
    if (do_load) begin
      smem <= sinit;
      for (int a = 0; a < ML; a++) dmem[a] <= 8'hee;
    end else begin
      if (s_write_enable) smem[s_address] <= s_ram_in;
      if (dec_write_enable) dmem[dec_address] <= dec_ram_in;
    end
    s_ram_out   <= smem[s_address];
    enc_rom_out <= emem[enc_address];
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] ks[ML];
  logic [7:0] pt[ML];
  logic [7:0] key[16];

  logic       exp_swe[NC];
  logic [7:0] exp_sa [NC];
  logic [7:0] exp_sd [NC];
  logic       exp_dwe[NC];
  logic [4:0] exp_da [NC];
  logic [7:0] exp_dd [NC];
  logic       exp_fin[NC];
  logic       exp_val[NC];
  int         exp_end;

  task automatic check(input string nm, input int c,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0d: got=%h want=%h",
               nm, c, got, want);
    end
  endtask

  function automatic bit printable(input logic [7:0] d);
    return d == 8'h20 || (d >= 8'h61 && d <= 8'h7a);
  endfunction

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  // Key scheduling into sinit.
  task automatic ksa(input int len);
    int j;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < 256; i++) sinit[i] = 8'(i);
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(sinit[i]) + int'(key[i % len])) % 256;
      t = sinit[i];
      sinit[i] = sinit[j];
      sinit[j] = t;
    end
  endtask

  // Plain RC4 keystream from sinit.
  task automatic ks_gen();
    logic [7:0] s[256];
    logic [7:0] t;
    int i, j;
    s = sinit;
    i = 0;
    j = 0;
    for (int n = 0; n < ML; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      ks[n] = s[(int'(s[i]) + int'(s[j])) % 256];
    end
  endtask

  task automatic load_s();
    for (int n = 0; n < ML; n++) emem[n] = pt[n] ^ ks[n];
    @(negedge clk);
    do_load = 1'b1;
    @(posedge clk);
    #1 do_load = 1'b0;
  endtask

  // Expected per-cycle activity from the current S RAM contents.
  task automatic model_pass();
    logic [7:0] s[256];
    logic [7:0] t;
    logic [7:0] d;
    int i, j, e, c;
    bit ok;
    s = smem;
    i = 0;
    j = 0;
    ok = 1'b1;
    e = 10 * ML;
    for (int n = 0; n < NC; n++) begin
      exp_swe[n] = 1'b0;
      exp_sa[n]  = 8'h0;
      exp_sd[n]  = 8'h0;
      exp_dwe[n] = 1'b0;
      exp_da[n]  = 5'h0;
      exp_dd[n]  = 8'h0;
    end
    for (int n = 0; n < ML; n++) begin
      c = 10 * n;
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      exp_swe[c + 4] = 1'b1;
      exp_sa[c + 4]  = 8'(i);
      exp_sd[c + 4]  = s[i];
      exp_swe[c + 5] = 1'b1;
      exp_sa[c + 5]  = 8'(j);
      exp_sd[c + 5]  = s[j];
      d = s[(int'(s[i]) + int'(s[j])) % 256] ^ emem[n];
      exp_dwe[c + 8] = 1'b1;
      exp_da[c + 8]  = 5'(n);
      exp_dd[c + 8]  = d;
      if (!printable(d)) begin
        e  = c + 9;
        ok = 1'b0;
        break;
      end
    end
    exp_end = e;
    for (int n = 0; n < NC; n++) begin
      exp_fin[n] = (n >= e);
      exp_val[n] = (n >= e) && ok;
    end
  endtask

  task automatic cmp(input int c);
    check("s_write", c,
          {15'h0, s_write_enable,
           s_write_enable ? {s_address, s_ram_in} : 16'h0},
          {15'h0, exp_swe[c], exp_sa[c], exp_sd[c]});
    check("dec_write", c,
          {18'h0, dec_write_enable,
           dec_write_enable ? {dec_address, dec_ram_in} : 13'h0},
          {18'h0, exp_dwe[c], exp_da[c], exp_dd[c]});
    check("status", c,
          {30'h0, finished, msg_valid},
          {30'h0, exp_fin[c], exp_val[c]});
  endtask

  // One pass; the accept edge is the posedge after entry
  // (after a fresh start edge when gen_edge is set).
  task automatic run_pass(input int pulse_at, input int extra,
                          input bit gen_edge);
    if (gen_edge) begin
      @(negedge clk) start = 1'b0;
      @(negedge clk) start = 1'b1;
    end
    model_pass();
    for (int c = 0; c <= exp_end + 3 + extra; c++) begin
      @(negedge clk);
      cmp(c);
      if (c == pulse_at) start = 1'b0;
      if (c == pulse_at + 1) start = 1'b1;
    end
  endtask

  logic [71:0] key_ks;
  logic [71:0] ptxt;
  logic [63:0] zeros;
  int          kk;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int n = 0; n < ML; n++) emem[n] = 8'h0;
    repeat (3) @(negedge clk);
    check("reset_out", 0,
          {s_write_enable, dec_write_enable, finished, msg_valid,
           s_address, s_ram_in, 3'b0, enc_address},
          32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_out", 0,
          {9'h0, dec_address, dec_ram_in, s_write_enable,
           dec_write_enable, finished, msg_valid, 6'h0},
          32'h0);

    // Identity S: keystream must start 02, 05.
    for (int i = 0; i < 256; i++) sinit[i] = 8'(i);
    ks_gen();
    check("ks_ident0", 0, {24'h0, ks[0]}, 32'h02);
    check("ks_ident1", 1, {24'h0, ks[1]}, 32'h05);
    for (int n = 0; n < ML; n++) pt[n] = rand_char();
    load_s();
    run_pass(-5, 0, 1'b1);
    for (int n = 0; n < ML; n++)
      check("dec_ident", n, {24'h0, dmem[n]}, {24'h0, pt[n]});

    // Key "Key": known keystream, lowercase plaintext.
    key[0] = 8'h4b;
    key[1] = 8'h65;
    key[2] = 8'h79;
    ksa(3);
    ks_gen();
    key_ks = 72'heb9f7781b734ca72a7;
    ptxt   = 72'h706c61696e74657874;
    for (int n = 0; n < 9; n++)
      check("ks_key", n, {24'h0, ks[n]},
            {24'h0, key_ks[8 * (8 - n) +: 8]});
    for (int n = 0; n < ML; n++)
      pt[n] = (n < 9) ? ptxt[8 * (8 - n) +: 8] : 8'h20;
    load_s();
    run_pass(-5, 0, 1'b1);
    for (int n = 0; n < 9; n++)
      check("dec_plain", n, {24'h0, dmem[n]},
            {24'h0, ptxt[8 * (8 - n) +: 8]});

    // Byte 3 decrypts to 'A': abort, later bytes untouched.
    pt[3] = 8'h41;
    load_s();
    run_pass(-5, 0, 1'b1);
    check("abort_cycle", 0, exp_end, 39);
    check("abort_byte", 3, {24'h0, dmem[3]}, 32'h41);
    for (int n = 4; n < ML; n++)
      check("untouched", n, {24'h0, dmem[n]}, 32'hee);

    // Reset in the middle of a pass.
    for (int n = 0; n < 5; n++) key[n] = 8'($urandom);
    ksa(5);
    ks_gen();
    for (int n = 0; n < ML; n++) pt[n] = rand_char();
    load_s();
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    for (int c = 0; c <= 15; c++) @(negedge clk);
    check("pre_rst_we", 15, {31'h0, s_write_enable}, 32'h1);
    reset = 1'b1;
    start = 1'b0;
    #1;
    zeros = {s_address, s_ram_in, 3'b0, enc_address,
             3'b0, dec_address, dec_ram_in, 4'h0,
             s_write_enable, dec_write_enable,
             finished, msg_valid, 8'h0};
    check("rst_hi", 15, zeros[63:32], 32'h0);
    check("rst_lo", 15, zeros[31:0], 32'h0);
    @(negedge clk) reset = 1'b0;
    run_pass(-5, 0, 1'b1);

    // Start held high with a mid-pass glitch: one pass only.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    run_pass(50, 20, 1'b0);
    run_pass(-5, 0, 1'b1);

    // Random keys and messages, some with a bad byte.
    for (int it = 0; it < 8; it++) begin
      kk = $urandom_range(3, 8);
      for (int n = 0; n < kk; n++) key[n] = 8'($urandom);
      ksa(kk);
      ks_gen();
      for (int n = 0; n < ML; n++) pt[n] = rand_char();
      if (it % 2 == 1)
        pt[$urandom_range(0, ML - 1)] = 8'($urandom_range(0, 8'h1f));
      load_s();
      run_pass(-5, 0, 1'b1);
      for (int n = 0; n < ML; n++) begin
        if (10 * n + 8 < exp_end)
          check("dec_rand", n, {24'h0, dmem[n]}, {24'h0, pt[n]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
